// File: rtl/spi_target.sv
// spi_target: SPI mode 0 (CPOL=0, CPHA=0), MSB-first target endpoint.
// SCK/CSN/MOSI are oversampled by the 48 MHz system clock through
// synchronisers. A byte-wide TX holding register feeds the shifter.
//
// Ports:
//   clk, reset            system clock, async active-high reset
//   spi_clk_i/csn_i/mosi_i  raw SPI pins from the external master
//   spi_miso_o            MISO data (tx_shift[7])
//   spi_miso_drive_o      MISO pad output enable, high while selected
//   selected_o            synchronised active-high select status
//   tx_byte_i, tx_en_i    load request for the TX holding register
//   tx_ready_o            holding register is empty
//   rx_byte_o, rx_en_o    last received byte and its one-cycle strobe
//   tx_underrun_o         sticky underrun flag (only with macro below)
//
// Optional feature macro: SPI_TARGET_UNDERRUN_EN adds tx_underrun_o.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_drive_o,
  output logic       selected_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_en_i,
  output logic       tx_ready_o,
`ifdef SPI_TARGET_UNDERRUN_EN
  output logic       tx_underrun_o,
`endif
  output logic [7:0] rx_byte_o,
  output logic       rx_en_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic sck_prev, csn_prev, mosi_q;
  logic sck_rise, sck_fall, csn_fall, csn_rise;

  state_t     state;
  logic [7:0] tx_shift, rx_shift, hold_data;
  logic       hold_valid, byte_done;
  logic [2:0] bit_cnt;

  logic       reload, accept, bypass;
  logic [7:0] reload_byte;

  // Synchronisers followed by registered edge pulses. mosi_q is delayed by
  // the same amount as the pulses so it lines up with sck_rise. CSN resets
  // high so a master already selecting at reset release still gives a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      csn_prev  <= 1'b1;
      mosi_q    <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
      csn_fall  <= 1'b0;
      csn_rise  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk_i};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      csn_prev  <= csn_sync[SYNC_STAGES-1];
      mosi_q    <= mosi_sync[SYNC_STAGES-1];
      sck_rise  <= sck_sync[SYNC_STAGES-1] & ~sck_prev;
      sck_fall  <= ~sck_sync[SYNC_STAGES-1] & sck_prev;
      csn_fall  <= ~csn_sync[SYNC_STAGES-1] & csn_prev;
      csn_rise  <= csn_sync[SYNC_STAGES-1] & ~csn_prev;
    end
  end

  // A reload happens at selection and at the falling edge that ends a byte.
  // A load request arriving in the same cycle with the holding register
  // empty skips the register and goes straight into the shifter.
  always_comb begin
    reload      = csn_fall | ((state == ACTIVE) & sck_fall & byte_done & ~csn_rise);
    accept      = tx_en_i & ~hold_valid;
    bypass      = reload & accept;
    reload_byte = 8'hFF;
    if (hold_valid)  reload_byte = hold_data;
    else if (bypass) reload_byte = tx_byte_i;
  end

`ifdef SPI_TARGET_UNDERRUN_EN
  logic underrun_hit;
  assign underrun_hit = ~hold_valid & ~bypass;
`endif

  // Main control: holding register, shifters, bit counter and select FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx_shift   <= 8'hFF;
      rx_shift   <= 8'h00;
      hold_data  <= 8'h00;
      hold_valid <= 1'b0;
      byte_done  <= 1'b0;
      bit_cnt    <= 3'd0;
      rx_byte_o  <= 8'h00;
      rx_en_o    <= 1'b0;
`ifdef SPI_TARGET_UNDERRUN_EN
      tx_underrun_o <= 1'b0;
`endif
    end else begin
      rx_en_o <= 1'b0;

      if (reload) begin
        hold_valid <= 1'b0;
      end else if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_byte_i;
      end

      if (csn_rise) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        tx_shift  <= 8'hFF;
      end else if (csn_fall) begin
        state     <= ACTIVE;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        rx_shift  <= 8'h00;
        tx_shift  <= reload_byte;
`ifdef SPI_TARGET_UNDERRUN_EN
        tx_underrun_o <= underrun_hit;
`endif
      end else if (state == ACTIVE) begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_q};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_byte_o <= {rx_shift[6:0], mosi_q};
            rx_en_o   <= 1'b1;
            byte_done <= 1'b1;
          end
        end
        if (sck_fall) begin
          if (byte_done) begin
            tx_shift  <= reload_byte;
            byte_done <= 1'b0;
`ifdef SPI_TARGET_UNDERRUN_EN
            tx_underrun_o <= tx_underrun_o | underrun_hit;
`endif
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b1};
          end
        end
      end
    end
  end

  assign spi_miso_o       = tx_shift[7];
  assign selected_o       = (state == ACTIVE);
  assign spi_miso_drive_o = (state == ACTIVE);
  assign tx_ready_o       = ~hold_valid;

endmodule

// File: tb/tb_spi_target.sv
// Testbench for spi_target: the bench acts as SPI master at clk/12-ish,
// keeps a one-slot holding-register model plus expected-byte queues, and a
// monitor process checks every rx_en_o strobe against the RX queue.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       tx_en = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       spi_miso, spi_miso_drive, selected, tx_ready, rx_en;
  logic [7:0] rx_byte;
`ifdef SPI_TARGET_UNDERRUN_EN
  logic       tx_underrun;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_under = 1'b0;

  logic [7:0] fr_mosi[4];
  int         fr_mid_cnt[4];
  logic [7:0] fr_mid_val[4];
  bit         fr_bnd_byp[4];
  logic [7:0] fr_bnd_val[4];
  bit         fr_csn_byp;
  logic [7:0] fr_csn_val;
  int         fr_abort;

  bit rx_en_prev = 1'b0;

  spi_target dut (
    .clk              (clk),
    .reset            (reset),
    .spi_clk_i        (spi_clk),
    .spi_csn_i        (spi_csn),
    .spi_mosi_i       (spi_mosi),
    .spi_miso_o       (spi_miso),
    .spi_miso_drive_o (spi_miso_drive),
    .selected_o       (selected),
    .tx_byte_i        (tx_byte),
    .tx_en_i          (tx_en),
    .tx_ready_o       (tx_ready),
`ifdef SPI_TARGET_UNDERRUN_EN
    .tx_underrun_o    (tx_underrun),
`endif
    .rx_byte_o        (rx_byte),
    .rx_en_o          (rx_en)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, got, exp);
    end
  endtask

  // Monitor: every rx_en_o strobe must match the next expected byte and
  // last exactly one cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_en_prev) checkOutput("rx_en_width", 8'(rx_en), 8'h00);
      rx_en_prev = rx_en;
      if (rx_en) begin
        if (exp_rx.size() == 0) checkOutput("rx_unexpected", 8'h01, 8'h00);
        else checkOutput("rx_byte", rx_byte, exp_rx.pop_front());
      end
    end else begin
      rx_en_prev = 1'b0;
    end
  end

  // Model of a reload: the byte sent next is the held byte, else a bypassed
  // byte, else the idle pattern (an underrun).
  task automatic modelReload(input bit byp, input logic [7:0] bval, input bit at_select);
    logic [7:0] e;
    bit hit;
    hit = 1'b0;
    if (m_valid) begin
      e = m_data;
      m_valid = 1'b0;
    end else if (byp) begin
      e = bval;
    end else begin
      e = 8'hFF;
      hit = 1'b1;
    end
    if (at_select) m_under = hit;
    else m_under = m_under | hit;
    exp_miso.push_back(e);
  endtask

  task automatic loadByte(input logic [7:0] b);
    tx_en = 1'b1;
    tx_byte = b;
    checkOutput("ready_before_load", 8'(tx_ready), 8'(!m_valid));
    @(negedge clk);
    tx_en = 1'b0;
    checkOutput("ready_after_load", 8'(tx_ready), 8'h00);
    if (!m_valid) begin
      m_valid = 1'b1;
      m_data = b;
    end
  endtask

  // Six-cycle SCK/CSN low phase; optionally raises tx_en_i exactly on the
  // cycle the reload takes effect (edge + SYNC_STAGES + 2).
  task automatic lowWait(input bit byp, input logic [7:0] val);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (byp && i == 3) begin
        tx_en = 1'b1;
        tx_byte = val;
      end
      if (byp && i == 4) begin
        tx_en = 1'b0;
        checkOutput("bypass_ready", 8'(tx_ready), 8'(!m_valid));
      end
    end
  endtask

  task automatic clearFrame();
    for (int k = 0; k < 4; k++) begin
      fr_mosi[k] = 8'h00;
      fr_mid_cnt[k] = 0;
      fr_mid_val[k] = 8'h00;
      fr_bnd_byp[k] = 1'b0;
      fr_bnd_val[k] = 8'h00;
    end
    fr_csn_byp = 1'b0;
    fr_csn_val = 8'h00;
    fr_abort = 0;
  endtask

  // One CSN window of nbytes bytes, configured through the fr_* arrays.
  task automatic applyStimulus(input int nbytes);
    logic [7:0] got;
    bit aborted;
    aborted = 1'b0;
    got = 8'h00;
    spi_csn = 1'b0;
    modelReload(fr_csn_byp, fr_csn_val, 1'b1);
    lowWait(fr_csn_byp, fr_csn_val);
    checkOutput("selected", 8'(selected), 8'h01);
    checkOutput("miso_drive", 8'(spi_miso_drive), 8'h01);
`ifdef SPI_TARGET_UNDERRUN_EN
    checkOutput("underrun_at_select", 8'(tx_underrun), 8'(m_under));
`endif
    for (int k = 0; k < nbytes; k++) begin
      int abort_k;
      abort_k = (k == nbytes - 1) ? fr_abort : 0;
      if (abort_k == 0) exp_rx.push_back(fr_mosi[k]);
      for (int b = 0; b < 8; b++) begin
        spi_mosi = fr_mosi[k][7-b];
        repeat (2) @(negedge clk);
        spi_clk = 1'b1;
        got[7-b] = spi_miso;
        repeat (6) @(negedge clk);
        if (b == 3) begin
          for (int j = 0; j < fr_mid_cnt[k]; j++) loadByte(fr_mid_val[k] ^ 8'(j * 8'hFF));
        end
        spi_clk = 1'b0;
        if (abort_k != 0 && b + 1 == abort_k) begin
          repeat (6) @(negedge clk);
          aborted = 1'b1;
          break;
        end
        if (b == 7) begin
          modelReload(fr_bnd_byp[k], fr_bnd_val[k], 1'b0);
          lowWait(fr_bnd_byp[k], fr_bnd_val[k]);
        end else begin
          lowWait(1'b0, 8'h00);
        end
      end
      if (aborted) break;
      checkOutput("miso_byte", got, exp_miso.pop_front());
    end
    spi_csn = 1'b1;
    repeat (10) @(negedge clk);
    exp_miso.delete();
    checkOutput("deselected", 8'(selected), 8'h00);
    checkOutput("ready_after_frame", 8'(tx_ready), 8'(!m_valid));
`ifdef SPI_TARGET_UNDERRUN_EN
    checkOutput("underrun_after_frame", 8'(tx_underrun), 8'(m_under));
`endif
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_miso"}, 8'(spi_miso), 8'h01);
    checkOutput({tag, "_drive"}, 8'(spi_miso_drive), 8'h00);
    checkOutput({tag, "_selected"}, 8'(selected), 8'h00);
    checkOutput({tag, "_ready"}, 8'(tx_ready), 8'h01);
    checkOutput({tag, "_rx_byte"}, rx_byte, 8'h00);
    checkOutput({tag, "_rx_en"}, 8'(rx_en), 8'h00);
`ifdef SPI_TARGET_UNDERRUN_EN
    checkOutput({tag, "_underrun"}, 8'(tx_underrun), 8'h00);
`endif
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single byte");
    loadByte(8'hA5);
    clearFrame();
    fr_mosi[0] = 8'h3C;
    applyStimulus(1);

    $display("[TB] back-to-back");
    loadByte(8'h11);
    clearFrame();
    fr_mosi[0] = 8'hF0;
    fr_mosi[1] = 8'h0F;
    fr_mid_cnt[0] = 1;
    fr_mid_val[0] = 8'h22;
    applyStimulus(2);

    $display("[TB] underrun");
    clearFrame();
    fr_mosi[0] = 8'h12;
    fr_mosi[1] = 8'h34;
    applyStimulus(2);
    loadByte(8'h33);
    clearFrame();
    fr_mosi[0] = 8'h56;
    applyStimulus(1);

    $display("[TB] aborted byte");
    clearFrame();
    fr_mosi[0] = 8'hE7;
    fr_mid_cnt[0] = 1;
    fr_mid_val[0] = 8'h5A;
    fr_abort = 5;
    applyStimulus(1);
    clearFrame();
    fr_mosi[0] = 8'h81;
    applyStimulus(1);

    $display("[TB] handshake");
    loadByte(8'h66);
    loadByte(8'h77);
    clearFrame();
    fr_mosi[0] = 8'h5C;
    applyStimulus(1);
    clearFrame();
    fr_mosi[0] = 8'h9D;
    fr_csn_byp = 1'b1;
    fr_csn_val = 8'hC3;
    fr_bnd_byp[0] = 1'b1;
    fr_bnd_val[0] = 8'h4B;
    fr_mosi[1] = 8'h2E;
    applyStimulus(2);

    $display("[TB] reset mid-transfer");
    loadByte(8'h99);
    spi_csn = 1'b0;
    repeat (10) @(negedge clk);
    spi_clk = 1'b1;
    repeat (6) @(negedge clk);
    spi_clk = 1'b0;
    repeat (6) @(negedge clk);
    spi_clk = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 checkResetValues("async_reset");
    spi_clk = 1'b0;
    spi_csn = 1'b1;
    m_valid = 1'b0;
    m_under = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("ready_after_reset", 8'(tx_ready), 8'h01);
    checkOutput("idle_after_reset", 8'(selected), 8'h00);

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      clearFrame();
      if ($urandom_range(1, 0) == 1) begin
        loadByte(8'($urandom));
        if ($urandom_range(3, 0) == 0) loadByte(8'($urandom));
      end
      nb = $urandom_range(3, 1);
      for (int k = 0; k < 4; k++) begin
        fr_mosi[k] = 8'($urandom);
        fr_mid_cnt[k] = $urandom_range(2, 0);
        fr_mid_val[k] = 8'($urandom);
        fr_bnd_byp[k] = ($urandom_range(5, 0) == 0);
        fr_bnd_val[k] = 8'($urandom);
      end
      fr_csn_byp = ($urandom_range(5, 0) == 0);
      fr_csn_val = 8'($urandom);
      fr_abort = ($urandom_range(6, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
      applyStimulus(nb);
    end

    repeat (5) @(negedge clk);
    checkOutput("rx_pending", 8'(exp_rx.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
